// File: rtl/sar_column_converter_pkg.sv
// Shared definitions for the SAR column converter: default geometry and FSM state encoding.
package sar_pkg;

  localparam int SAR_ADC_BITS      = 8;
  localparam int SAR_DECODER_WIDTH = 2;

  typedef logic [2:0] sar_state_t;

  localparam sar_state_t ST_IDLE    = 3'd0;
  localparam sar_state_t ST_SETTLE  = 3'd1;
  localparam sar_state_t ST_TRIAL   = 3'd2;
  localparam sar_state_t ST_COMPARE = 3'd3;
  localparam sar_state_t ST_OUTPUT  = 3'd4;
  localparam sar_state_t ST_DONE    = 3'd5;

endpackage

// File: rtl/sar_column_converter_register.sv
// Successive-approximation register: holds the partial result and the bit under trial.
module sar_register
  import sar_pkg::*;
#(
  parameter int ADC_BITS = SAR_ADC_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic                trial,
  input  logic                decide,
  input  logic                comp,
  output logic [ADC_BITS-1:0] trial_code,
  output logic [ADC_BITS-1:0] result,
  output logic                last_bit
);

  localparam int IW = (ADC_BITS > 1) ? $clog2(ADC_BITS) : 1;
  localparam logic [ADC_BITS-1:0] LSB_ONE = ADC_BITS'(1);

  logic [ADC_BITS-1:0] result_r;
  logic [IW-1:0]       bit_idx_r;
  logic [ADC_BITS-1:0] bit_mask_s;
  logic [ADC_BITS-1:0] next_mask_s;
  logic [ADC_BITS-1:0] decided_s;

  // Trial code for the next cycle; when a decision lands on the same edge the next trial bit is already folded in.
  always_comb begin
    bit_mask_s  = LSB_ONE << bit_idx_r;
    next_mask_s = bit_mask_s >> 1'b1;
    decided_s   = comp ? (result_r | bit_mask_s) : result_r;
    last_bit    = (bit_idx_r == IW'(0));
    if (!trial) begin
      trial_code = {ADC_BITS{1'b0}};
    end else if (decide) begin
      trial_code = decided_s | next_mask_s;
    end else begin
      trial_code = result_r | bit_mask_s;
    end
  end

  // Result and bit index update: cleared on reset, restarted on init, stepped on each decision.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_r  <= {ADC_BITS{1'b0}};
      bit_idx_r <= IW'(0);
    end else if (init) begin
      result_r  <= {ADC_BITS{1'b0}};
      bit_idx_r <= IW'(ADC_BITS - 1);
    end else if (decide) begin
      result_r <= decided_s;
      if (!last_bit) begin
        bit_idx_r <= bit_idx_r - IW'(1);
      end else begin
        bit_idx_r <= bit_idx_r;
      end
    end else begin
      result_r  <= result_r;
      bit_idx_r <= bit_idx_r;
    end
  end

  assign result = result_r;

endmodule

// File: rtl/sar_column_converter.sv
// SAR ADC column controller: walks the column select, digitises each pixel and hands codes downstream.
module sar_column_converter
  import sar_pkg::*;
#(
  parameter int ADC_BITS      = SAR_ADC_BITS,
  parameter int DECODER_WIDTH = SAR_DECODER_WIDTH,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     comp_in,
  input  logic                     data_ready,
  output logic                     busy,
  output logic                     done,
  output logic [DECODER_WIDTH-1:0] col_sel,
  output logic [ADC_BITS-1:0]      dac_code,
  output logic [ADC_BITS-1:0]      data_out,
  output logic [DECODER_WIDTH-1:0] data_col,
  output logic                     data_valid
);

  localparam int SCW = $clog2(SETTLE_CYCLES + 1);

  sar_state_t                 state_r;
  sar_state_t                 state_next_s;
  logic [SCW-1:0]             settle_cnt_r;
  logic [DECODER_WIDTH-1:0]   col_sel_r;
  logic [DECODER_WIDTH-1:0]   data_col_r;
  logic                       data_valid_r;
  logic                       done_r;
  logic                       busy_r;
  logic [ADC_BITS-1:0]        dac_code_r;
  logic                       init_s;
  logic                       decide_s;
  logic                       trial_s;
  logic                       xfer_s;
  logic                       last_col_s;
  logic [ADC_BITS-1:0]        trial_code_s;
  logic [ADC_BITS-1:0]        result_s;
  logic                       last_bit_s;

  sar_register #(.ADC_BITS(ADC_BITS)) u_sar_register (
    .clk        (clk),
    .reset      (reset),
    .init       (init_s),
    .trial      (trial_s),
    .decide     (decide_s),
    .comp       (comp_in),
    .trial_code (trial_code_s),
    .result     (result_s),
    .last_bit   (last_bit_s)
  );

  // Next-state decode and the strobes that steer the approximation register.
  always_comb begin
    last_col_s = (col_sel_r == {DECODER_WIDTH{1'b1}});
    xfer_s     = (state_r == ST_OUTPUT) && data_ready;
    case (state_r)
      ST_IDLE:    state_next_s = start ? ST_SETTLE : ST_IDLE;
      ST_SETTLE:  state_next_s = (settle_cnt_r == SCW'(0)) ? ST_TRIAL : ST_SETTLE;
      ST_TRIAL:   state_next_s = ST_COMPARE;
      ST_COMPARE: state_next_s = last_bit_s ? ST_OUTPUT : ST_TRIAL;
      ST_OUTPUT: begin
        if (!data_ready) begin
          state_next_s = ST_OUTPUT;
        end else if (last_col_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SETTLE;
        end
      end
      ST_DONE:    state_next_s = ST_IDLE;
      default:    state_next_s = ST_IDLE;
    endcase
    init_s   = ((state_r == ST_IDLE) && start) || (xfer_s && !last_col_s);
    decide_s = (state_r == ST_COMPARE);
    trial_s  = (state_next_s == ST_TRIAL) || (state_next_s == ST_COMPARE);
  end

  // Controller state, settle timing, column walk and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      settle_cnt_r <= SCW'(0);
      col_sel_r    <= {DECODER_WIDTH{1'b0}};
      data_col_r   <= {DECODER_WIDTH{1'b0}};
      data_valid_r <= 1'b0;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
      dac_code_r   <= {ADC_BITS{1'b0}};
    end else begin
      state_r      <= state_next_s;
      busy_r       <= (state_next_s != ST_IDLE);
      done_r       <= (state_next_s == ST_DONE);
      data_valid_r <= (state_next_s == ST_OUTPUT);
      dac_code_r   <= trial_code_s;
      if ((state_next_s == ST_SETTLE) && (state_r != ST_SETTLE)) begin
        settle_cnt_r <= SCW'(SETTLE_CYCLES - 1);
      end else if ((state_r == ST_SETTLE) && (settle_cnt_r != SCW'(0))) begin
        settle_cnt_r <= settle_cnt_r - SCW'(1);
      end else begin
        settle_cnt_r <= settle_cnt_r;
      end
      if ((state_r == ST_IDLE) && start) begin
        col_sel_r <= {DECODER_WIDTH{1'b0}};
      end else if (xfer_s && !last_col_s) begin
        col_sel_r <= col_sel_r + DECODER_WIDTH'(1);
      end else if (state_r == ST_DONE) begin
        col_sel_r <= {DECODER_WIDTH{1'b0}};
      end else begin
        col_sel_r <= col_sel_r;
      end
      if (state_next_s == ST_OUTPUT) begin
        data_col_r <= col_sel_r;
      end else begin
        data_col_r <= data_col_r;
      end
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign col_sel    = col_sel_r;
  assign dac_code   = dac_code_r;
  assign data_out   = result_s;
  assign data_col   = data_col_r;
  assign data_valid = data_valid_r;

endmodule

// File: tb/tb_sar_column_converter.sv
// Directed bench for sar_column_converter with a per-column comparator model driven from col_sel.
module tb_sar_column_converter;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       comp_in;
  logic       data_ready;
  logic       busy;
  logic       done;
  logic [1:0] col_sel;
  logic [7:0] dac_code;
  logic [7:0] data_out;
  logic [1:0] data_col;
  logic       data_valid;

  logic [7:0] tgt [4];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign comp_in = (tgt[col_sel] >= dac_code);

  sar_column_converter dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .comp_in    (comp_in),
    .data_ready (data_ready),
    .busy       (busy),
    .done       (done),
    .col_sel    (col_sel),
    .dac_code   (dac_code),
    .data_out   (data_out),
    .data_col   (data_col),
    .data_valid (data_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_col_sel"}, 32'(col_sel), 32'd0);
    check({tag, "_dac"}, 32'(dac_code), 32'd0);
    check({tag, "_data_out"}, 32'(data_out), 32'd0);
    check({tag, "_data_col"}, 32'(data_col), 32'd0);
    check({tag, "_valid"}, 32'(data_valid), 32'd0);
  endtask

  // One start pulse and a cycle-indexed monitor of the whole row (cyc = rising edges since the start edge).
  task automatic run_row(input int stall_col, input int stall_len, input int restart_cyc,
                         input int abort_cyc, input bit check_trials);
    int ncol, dones, exp_cyc, last_xfer, stall_left;
    bit prev_valid, fin;
    logic [7:0] cap_out, msb;
    logic [1:0] cap_col;
    ncol = 0; dones = 0; exp_cyc = 18; last_xfer = -100; stall_left = stall_len;
    prev_valid = 1'b0; fin = 1'b0; cap_out = 8'h00; cap_col = 2'd0; msb = 8'h80;
    data_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_col_sel", 32'(col_sel), 32'd0);
    check("settle_dac0", 32'(dac_code), 32'd0);
    for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
      @(negedge clk);
      start = (cyc == restart_cyc);
      if (abort_cyc > 0 && cyc == abort_cyc) begin
        check("abort_col_sel", 32'(col_sel), 32'd2);
        check("abort_dac", 32'(dac_code), 32'h80);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_zero("abort");
        repeat (3) begin
          @(negedge clk);
          check("abort_idle", 32'({busy, done}), 32'd0);
        end
        fin = 1'b1;
      end else begin
        if (check_trials && ncol == 0 && cyc >= 2 && cyc <= 17)
          check("trial_code", 32'(dac_code), 32'(msb >> ((cyc - 2) / 2)));
        if (cyc == 1) check("settle_dac1", 32'(dac_code), 32'd0);
        if (data_valid && !prev_valid) check("valid_time", 32'(cyc), 32'(exp_cyc));
        prev_valid = data_valid;
        if (ncol == stall_col && stall_left > 0 && (data_valid || stall_left < stall_len)) begin
          if (stall_left == stall_len) begin
            cap_out = data_out;
            cap_col = data_col;
          end else begin
            check("stall_valid", 32'(data_valid), 32'd1);
            check("stall_out", 32'(data_out), 32'(cap_out));
            check("stall_col", 32'(data_col), 32'(cap_col));
            check("stall_sel", 32'(col_sel), 32'(ncol));
          end
          data_ready = 1'b0;
          stall_left--;
        end else if (data_valid) begin
          check("data_out", 32'(data_out), 32'(tgt[2'(ncol)]));
          check("data_col", 32'(data_col), 32'(ncol));
          check("out_dac", 32'(dac_code), 32'd0);
          data_ready = 1'b1;
          exp_cyc = cyc + 19;
          last_xfer = cyc;
          ncol++;
        end
        if (done) begin
          dones++;
          check("done_time", 32'(cyc), 32'(last_xfer + 1));
        end else if (dones > 0) begin
          check("end_busy", 32'(busy), 32'd0);
          check("end_col_sel", 32'(col_sel), 32'd0);
          fin = 1'b1;
        end
      end
    end
    if (abort_cyc == 0) begin
      check("row_dones", 32'(dones), 32'd1);
      check("row_cols", 32'(ncol), 32'd4);
      check("row_end", 32'(fin), 32'd1);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; data_ready = 1'b0;
    tgt = '{8'h00, 8'h00, 8'h00, 8'h00};
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_zero("idle");

    tgt = '{8'hA5, 8'hA5, 8'hA5, 8'hA5};
    run_row(-1, 0, 0, 0, 1'b0);
    tgt = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_row(-1, 0, 0, 0, 1'b0);
    tgt = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_row(-1, 0, 0, 0, 1'b1);
    tgt = '{8'h10, 8'h7F, 8'h80, 8'hC3};
    run_row(-1, 0, 0, 0, 1'b0);
    run_row(1, 5, 0, 0, 1'b0);
    tgt = '{8'hA5, 8'hA5, 8'hA5, 8'hA5};
    run_row(-1, 0, 21, 0, 1'b0);
    tgt = '{8'h10, 8'h7F, 8'h80, 8'hC3};
    run_row(-1, 0, 0, 41, 1'b0);
    run_row(-1, 0, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
